// File: rtl/twiddle_stream_gen.sv
// twiddle_stream_gen: builds a power table of omega mod Q, then streams per-stage NTT twiddle pairs
module twiddle_stream_gen #(
    parameter int WIDTH = 18,
    parameter int N     = 16,
    parameter int LOGN  = 4,
    parameter int Q     = 12289
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] omega,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] weight_1,
    output logic [WIDTH-1:0] weight_2,
    output logic [LOGN-1:0]  stage,
    output logic             last,
    output logic             busy,
    output logic             done
);
    localparam int H  = N / 2;
    localparam int B  = N / 4;
    localparam int IW = LOGN - 1;
    localparam logic [WIDTH-1:0]   QW = WIDTH'(Q);
    localparam logic [2*WIDTH-1:0] QP = (2*WIDTH)'(Q);

    typedef enum logic [1:0] {IDLE, BUILD, STREAM} state_t;

    state_t             state;
    logic [WIDTH-1:0]   tbl [H];
    logic [WIDTH-1:0]   w_reg, acc, red;
    logic [IW-1:0]      idx, k;
    logic [LOGN-1:0]    s;
    logic [2*WIDTH-1:0] prod;

    function automatic logic [IW-1:0] expo(input int j, input logic [LOGN-1:0] st);
        return IW'((j & ((1 << st) - 1)) << (LOGN - 1 - int'(st)));
    endfunction

    assign prod      = {{WIDTH{1'b0}}, acc} * {{WIDTH{1'b0}}, w_reg};
    assign red       = WIDTH'(prod % QP);
    assign weight_1  = out_valid ? tbl[expo(2 * int'(k), s)] : '0;
    assign weight_2  = out_valid ? tbl[expo(2 * int'(k) + 1, s)] : '0;
    assign stage     = s;
    assign last      = out_valid && s == LOGN'(LOGN - 1) && k == IW'(B - 1);

    // Power table: seed T[0] on an accepted start, then one new power per BUILD cycle
    always_ff @(posedge clk)
        if (state == IDLE && start) tbl[0] <= WIDTH'(1);
        else if (state == BUILD) tbl[idx] <= red;

    // Control FSM: capture root, walk the build index, then step (s,k) on each handshake
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state     <= IDLE;
            w_reg     <= '0;
            acc       <= '0;
            idx       <= '0;
            s         <= '0;
            k         <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    w_reg <= omega % QW;
                    acc   <= WIDTH'(1);
                    idx   <= IW'(1);
                    busy  <= 1'b1;
                    state <= BUILD;
                end
                BUILD: begin
                    acc <= red;
                    idx <= idx + 1'b1;
                    if (idx == IW'(H - 1)) begin
                        state     <= STREAM;
                        out_valid <= 1'b1;
                        s         <= '0;
                        k         <= '0;
                    end
                end
                STREAM: if (out_ready) begin
                    if (k == IW'(B - 1)) begin
                        k <= '0;
                        if (s == LOGN'(LOGN - 1)) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            s         <= '0;
                        end else s <= s + 1'b1;
                    end else k <= k + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule

// File: tb/tb_twiddle_stream_gen.sv
// tb_twiddle_stream_gen: scenario checks of the twiddle streamer against a power-table model
module tb_twiddle_stream_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic s8 = 0, r8 = 1, v8, l8, b8, d8;
    logic [17:0] om8 = '0, a8, c8;
    logic [2:0] st8;
    logic s16 = 0, r16 = 1, v16, l16, b16, d16;
    logic [17:0] om16 = '0, a16, c16;
    logic [3:0] st16;

    twiddle_stream_gen #(.WIDTH(18), .N(8), .LOGN(3), .Q(17)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(s8), .omega(om8), .out_ready(r8),
        .out_valid(v8), .weight_1(a8), .weight_2(c8), .stage(st8), .last(l8),
        .busy(b8), .done(d8));

    twiddle_stream_gen #(.WIDTH(18), .N(16), .LOGN(4), .Q(12289)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s16), .omega(om16), .out_ready(r16),
        .out_valid(v16), .weight_1(a16), .weight_2(c16), .stage(st16), .last(l16),
        .busy(b16), .done(d16));

    int tests = 0, fails = 0;

    bit          rv[64], rr[64], rl[64], rd[64], rb[64];
    logic [17:0] rw1[64], rw2[64];
    int          rs[64];

    longint ew1[$], ew2[$];
    int     es[$];
    bit     el[$];

    function automatic longint pw(longint b, int e, longint q);
        longint r = 1;
        for (int i = 0; i < e; i++) r = r * b % q;
        return r;
    endfunction

    // Expected pair stream straight from the exponent rule e(j) = (j mod 2^s) * (N >> (s+1))
    function automatic void model(int n, int logn, longint q, longint om, int reps);
        longint b = om % q;
        ew1.delete(); ew2.delete(); es.delete(); el.delete();
        for (int r = 0; r < reps; r++)
            for (int s = 0; s < logn; s++)
                for (int k = 0; k < n / 4; k++) begin
                    ew1.push_back(pw(b, ((2 * k) % (1 << s)) * (n >> (s + 1)), q));
                    ew2.push_back(pw(b, ((2 * k + 1) % (1 << s)) * (n >> (s + 1)), q));
                    es.push_back(s);
                    el.push_back(s == logn - 1 && k == n / 4 - 1);
                end
    endfunction

    // Start one DUT and record one sample per cycle; ready pattern 0: always, 1: 1,0,0,...
    task automatic run(input int sel, input logic [17:0] om, input int mode, input bit hold, input int ncyc);
        bit rdy;
        @(negedge clk);
        if (sel == 0) begin s8 = 1; om8 = om; end else begin s16 = 1; om16 = om; end
        r8 = 1; r16 = 1;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            rv[i]  = sel ? v16 : v8;
            rw1[i] = sel ? a16 : a8;
            rw2[i] = sel ? c16 : c8;
            rs[i]  = sel ? int'(st16) : int'(st8);
            rl[i]  = sel ? l16 : l8;
            rd[i]  = sel ? d16 : d8;
            rb[i]  = sel ? b16 : b8;
            rdy    = (mode == 0) ? 1'b1 : (i % 3 == 0);
            r8 = rdy; r16 = rdy; rr[i] = rdy;
            s8  = (sel == 0) && hold;
            s16 = (sel == 1) && hold;
        end
        s8 = 0; s16 = 0; r8 = 1; r16 = 1;
        for (int i = 0; i < 200 && (b8 || b16); i++) @(negedge clk);
    endtask

    function automatic int beat_errs(input int ncyc, output int nacc, output int first_v, output int last_acc);
        int n = 0, e = 0;
        first_v = -1; last_acc = -1;
        for (int i = 1; i <= ncyc; i++) begin
            if (rv[i] && first_v < 0) first_v = i;
            if (rv[i] && rr[i]) begin
                if (n >= ew1.size() || rw1[i] !== ew1[n][17:0] || rw2[i] !== ew2[n][17:0] ||
                    rs[i] != es[n] || rl[i] != el[n]) e++;
                n++;
                last_acc = i;
            end
        end
        nacc = n;
        return e;
    endfunction

    function automatic int hold_errs(input int ncyc);
        int e = 0;
        for (int i = 1; i < ncyc; i++)
            if (rv[i] && !rr[i] && (!rv[i+1] || rw1[i+1] !== rw1[i] || rw2[i+1] !== rw2[i] ||
                rs[i+1] != rs[i] || rl[i+1] != rl[i])) e++;
        return e;
    endfunction

    function automatic int done_count(input int ncyc);
        int n = 0;
        for (int i = 1; i <= ncyc; i++) n += int'(rd[i]);
        return n;
    endfunction

    task automatic test_reset;
        #12;
        tests++;
        if ({v8, b8, d8, l8, a8, c8, st8} !== '0) begin
            fails++; $display("FAIL reset_n8 got %h want 0", {v8, b8, d8, l8, a8, c8, st8});
        end
        tests++;
        if ({v16, b16, d16, l16, a16, c16, st16} !== '0) begin
            fails++; $display("FAIL reset_n16 got %h want 0", {v16, b16, d16, l16, a16, c16, st16});
        end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_basic8;
        int nacc, fv, la, e;
        model(8, 3, 17, 2, 1);
        run(0, 18'd2, 0, 0, 16);
        e = beat_errs(16, nacc, fv, la);
        tests++; if (fv != 4) begin fails++; $display("FAIL basic_latency got %0d want 4", fv); end
        tests++; if (nacc != 6) begin fails++; $display("FAIL basic_beats got %0d want 6", nacc); end
        tests++; if (e != 0) begin fails++; $display("FAIL basic_pairs bad %0d want 0", e); end
        tests++; if (la != 9) begin fails++; $display("FAIL basic_last_cycle got %0d want 9", la); end
        tests++;
        if (!rd[10] || rb[10] || rv[10] || done_count(16) != 1) begin
            fails++; $display("FAIL basic_done done=%0d busy=%0d valid=%0d n=%0d want 1,0,0,1",
                              rd[10], rb[10], rv[10], done_count(16));
        end
        tests++; if (!rb[1]) begin fails++; $display("FAIL basic_busy got 0 want 1"); end
    endtask

    task automatic test_backpressure;
        int nacc, fv, la, e;
        model(8, 3, 17, 2, 1);
        run(0, 18'd2, 1, 0, 40);
        e = beat_errs(40, nacc, fv, la);
        tests++; if (nacc != 6) begin fails++; $display("FAIL bp_beats got %0d want 6", nacc); end
        tests++; if (e != 0) begin fails++; $display("FAIL bp_pairs bad %0d want 0", e); end
        tests++; if (hold_errs(40) != 0) begin fails++; $display("FAIL bp_hold bad %0d want 0", hold_errs(40)); end
        tests++;
        if (la < 1 || la > 38 || !rd[la+1] || done_count(40) != 1) begin
            fails++; $display("FAIL bp_done last=%0d dones=%0d want 1 pulse after last", la, done_count(40));
        end
    endtask

    task automatic test_default16;
        int nacc, fv, la, e, big;
        model(16, 4, 12289, 1479, 1);
        run(1, 18'd1479, 0, 0, 30);
        e = beat_errs(30, nacc, fv, la);
        big = 0;
        for (int i = 1; i <= 30; i++) if (rv[i] && (rw1[i] >= 18'd12289 || rw2[i] >= 18'd12289)) big++;
        tests++; if (fv != 8) begin fails++; $display("FAIL d16_latency got %0d want 8", fv); end
        tests++; if (nacc != 16) begin fails++; $display("FAIL d16_beats got %0d want 16", nacc); end
        tests++; if (e != 0) begin fails++; $display("FAIL d16_pairs bad %0d want 0", e); end
        tests++; if (big != 0) begin fails++; $display("FAIL d16_range got %0d over want 0", big); end
        tests++;
        if (rs[20] != 3 || rw1[20] !== 18'd1 || rw2[20] !== 18'd1479) begin
            fails++; $display("FAIL d16_stage3 got s%0d (%0d,%0d) want s3 (1,1479)", rs[20], rw1[20], rw2[20]);
        end
        tests++; if (!rd[24]) begin fails++; $display("FAIL d16_done got 0 want 1"); end
    endtask

    task automatic test_reset_midstream;
        int nacc, fv, la, e, dn;
        bit seen = 0;
        @(negedge clk); s8 = 1; om8 = 18'd2; r8 = 1;
        @(negedge clk); s8 = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (v8 && st8 == 3'd1) seen = 1;
        end
        tests++; if (!seen) begin fails++; $display("FAIL mid_reach_s1 got 0 want 1"); end
        #2 rst_n = 0;
        #1;
        tests++;
        if ({v8, b8, d8, l8, a8, c8, st8} !== '0) begin
            fails++; $display("FAIL mid_async got %h want 0", {v8, b8, d8, l8, a8, c8, st8});
        end
        dn = 0;
        repeat (3) begin @(negedge clk); dn += int'(d8); end
        tests++; if (dn != 0) begin fails++; $display("FAIL mid_no_done got %0d want 0", dn); end
        rst_n = 1;
        model(8, 3, 17, 2, 1);
        run(0, 18'd2, 0, 0, 16);
        e = beat_errs(16, nacc, fv, la);
        tests++;
        if (e != 0 || nacc != 6 || fv != 4) begin
            fails++; $display("FAIL mid_rerun bad=%0d beats=%0d lat=%0d want 0,6,4", e, nacc, fv);
        end
    endtask

    task automatic test_restart_hold;
        int nacc, fv, la, e;
        model(8, 3, 17, 2, 2);
        run(0, 18'd2, 0, 1, 22);
        e = beat_errs(22, nacc, fv, la);
        tests++; if (nacc != 12) begin fails++; $display("FAIL hold_beats got %0d want 12", nacc); end
        tests++; if (e != 0) begin fails++; $display("FAIL hold_pairs bad %0d want 0", e); end
        tests++;
        if (done_count(22) != 2 || !rd[10] || !rd[20]) begin
            fails++; $display("FAIL hold_done got %0d pulses want 2 at 10,20", done_count(22));
        end
        tests++;
        if (rb[10] || !rb[11] || rv[13] || !rv[14]) begin
            fails++; $display("FAIL hold_restart busy10=%0d busy11=%0d v13=%0d v14=%0d want 0,1,0,1",
                              rb[10], rb[11], rv[13], rv[14]);
        end
    endtask

    task automatic test_omega_reduce;
        int nacc, fv, la, e;
        model(8, 3, 17, 2, 1);
        run(0, 18'd19, 0, 0, 16);
        e = beat_errs(16, nacc, fv, la);
        tests++;
        if (e != 0 || nacc != 6) begin
            fails++; $display("FAIL omega19 bad=%0d beats=%0d want 0,6", e, nacc);
        end
    endtask

    initial begin
        test_reset;
        test_basic8;
        test_backpressure;
        test_default16;
        test_reset_midstream;
        test_restart_hold;
        test_omega_reduce;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/twiddle_stream_gen.md
Name: twiddle_stream_gen

Overview:
- Producer for the weight inputs of the dual-lane modular multiply stage; supplies one twiddle pair per beat for every butterfly pair of an N-point NTT.
- On start it builds a table of powers of a captured root omega (w^0..w^(N/2-1) mod Q) by repeated modular multiplication.
- It then streams (weight_1, weight_2) pairs stage by stage over a valid/ready handshake.

Parameters:
- WIDTH, 18, coefficient/weight width in bits.
- N, 16, transform length; power of two, ≥4.
- LOGN, 4, log2(N); number of NTT stages.
- Q, 12289, prime modulus; Q < 2^WIDTH.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- omega  in  WIDTH  primitive N-th root of unity mod Q; captured on accepted start.
- out_ready  in  1  downstream accepts current pair.
- out_valid  out  1  weight pair valid.
- weight_1  out  WIDTH  twiddle for butterfly j=2k.
- weight_2  out  WIDTH  twiddle for butterfly j=2k+1.
- stage  out  LOGN  stage index s of current pair.
- last  out  1  high with the final pair of the transform.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after final handshake.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; out_valid, busy, done, last = 0; weight_1, weight_2, stage = 0; table contents don't-care. Reset mid-BUILD or mid-STREAM aborts immediately, with no done pulse.
- FSM states: IDLE, BUILD, STREAM.
- IDLE: start=1 captures omega mod Q into w_reg, writes T[0]=1, sets busy=1 and enters BUILD.
- BUILD:
  - One entry per cycle: T[i] = (T[i-1]*w_reg) mod Q for i=1..N/2-1.
  - Full 2*WIDTH-bit product, reduced to [0,Q-1].
  - Lasts N/2-1 cycles, then enters STREAM with s=0, k=0.
- STREAM:
  - Beat (s,k), k=0..N/4-1; butterfly j=2k (lane 1) and j=2k+1 (lane 2).
  - Exponent e(j) = (j mod 2^s) * (N >> (s+1)).
  - weight_1=T[e(2k)], weight_2=T[e(2k+1)], stage=s.
  - out_valid=1 throughout STREAM.
  - Counters advance only on out_valid && out_ready; k wraps to 0 at N/4-1 and s increments.
  - While out_ready=0, weight_1, weight_2, stage and last are held stable.
  - last=1 exactly when s=LOGN-1 and k=N/4-1.
  - Handshake on the last beat: next cycle out_valid=0, busy=0, done=1 for one cycle, state=IDLE.
- Latency: first out_valid in cycle N/2 after the start cycle (start in cycle 0). Total beats = LOGN*N/4.
- start is ignored while busy=1, including a start in the same cycle as the final handshake. A new start is accepted in the done cycle (IDLE).
- omega is not validated. A non-primitive root still produces its power table deterministically. omega ≥ Q is reduced mod Q at capture.
- All table values and outputs are always in [0,Q-1].
- No combinational path from out_ready to out_valid. The weights are combinational reads of the registered table indexed by registered counters.

Test Plan:
- N=8, LOGN=3, Q=17, omega=2, start, out_ready=1:
  - Table = 1,2,4,8; first valid 4 cycles after start.
  - Pairs: s0 (1,1),(1,1); s1 (1,4),(1,4); s2 (1,2),(4,8).
  - last on the 6th beat; done pulses the next cycle; busy low.
- Same config, out_ready toggled 1,0,0,1,...: each pair is held unchanged while ready=0, the sequence is identical to the above, and no beat is dropped or duplicated.
- Default config (N=16, Q=12289), omega=1479, ready=1:
  - 16 beats; stage-3 pairs are w^0..w^7 in order (1,1479,...).
  - All values < 12289; T[i] = 1479^i mod 12289.
- rst_n pulsed low during STREAM at s=1: outputs go to 0 asynchronously with no done pulse. A later start with omega=2 (N=8, Q=17) reproduces the full sequence from s0.
- start held high throughout a run: the second start is ignored until done. Restart occurs in the done cycle and a second full sequence follows.
- omega=19 with Q=17: captured as 2; output is identical to the first scenario.
